riscv_test_sequencer: RTL and testbench

RISCV_TEST_SEQUENCER -- requirements
Module: riscv_test_sequencer

---
 rtl/riscv_test_sequencer.sv | 152 +++++++++++++++
 tb/tb_riscv_test_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_test_sequencer.sv
// Test sequencer: resets the core, runs it until PASS_PC, timeout or hang.
// Optional hang detection is built with TEST_SEQ_STALL_DETECT_EN.
module riscv_test_sequencer #(
  parameter logic [31:0] PASS_PC       = 32'h44,
  parameter int unsigned RESET_CYCLES  = 1,
  parameter logic [31:0] TIMEOUT_TICKS = 32'd5000,
  parameter logic [31:0] STALL_CYCLES  = 32'd16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] pc,
  input  logic [31:0] gp,
  output logic        core_rst,
  output logic        busy,
  output logic        done,
  output logic        passed,
  output logic        failed,
  output logic        timed_out,
  output logic        stalled,
  output logic [31:0] cycles
);

  typedef enum logic [1:0] {
    IDLE, RST_HOLD, RUN, DONE
  } state_t;

  localparam logic [7:0]  HOLD_LAST = 8'(RESET_CYCLES - 1);
  localparam logic [31:0] TO_LAST   = TIMEOUT_TICKS - 32'd1;

  state_t      state_q, state_d;
  logic [7:0]  hold_q, hold_d;
  logic [31:0] cyc_q, cyc_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;
  logic        to_q, to_d;
  logic        match, tmo, stall_hit;

  assign match = (pc == PASS_PC);
  assign tmo   = (cyc_q == TO_LAST);

`ifdef TEST_SEQ_STALL_DETECT_EN
  logic [31:0] prev_q;
  logic [31:0] scnt_q;
  logic        vld_q;
  logic        same;
  logic        stl_q, stl_d;

  // First RUN cycle has no previous pc to compare with.
  assign same      = vld_q && (pc == prev_q);
  assign stall_hit = same && (scnt_q == STALL_CYCLES - 32'd1);
  assign stalled   = stl_q;

  always_ff @(posedge clk) begin
    if (rst || state_q != RUN) begin
      prev_q <= '0;
      scnt_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      prev_q <= pc;
      vld_q  <= 1'b1;
      scnt_q <= same ? scnt_q + 32'd1 : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) stl_q <= 1'b0;
    else     stl_q <= stl_d;
  end
`else
  assign stall_hit = 1'b0 && (STALL_CYCLES != 32'd0);
  assign stalled   = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    cyc_d   = cyc_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    to_d    = to_q;
`ifdef TEST_SEQ_STALL_DETECT_EN
    stl_d   = stl_q;
`endif
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = RST_HOLD;
          hold_d  = '0;
          cyc_d   = '0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
          to_d    = 1'b0;
`ifdef TEST_SEQ_STALL_DETECT_EN
          stl_d   = 1'b0;
`endif
        end
      end
      RST_HOLD: begin
        if (hold_q == HOLD_LAST) state_d = RUN;
        else                     hold_d  = hold_q + 8'd1;
      end
      RUN: begin
        if (cyc_q != '1) cyc_d = cyc_q + 32'd1;
        // pc match wins over stall, stall over timeout
        if (match) begin
          state_d = DONE;
          pass_d  = (gp == 32'h1);
          fail_d  = (gp != 32'h1);
        end else if (stall_hit) begin
          state_d = DONE;
          fail_d  = 1'b1;
`ifdef TEST_SEQ_STALL_DETECT_EN
          stl_d   = 1'b1;
`endif
        end else if (tmo) begin
          state_d = DONE;
          fail_d  = 1'b1;
          to_d    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      hold_q  <= '0;
      cyc_q   <= '0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      cyc_q   <= cyc_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      to_q    <= to_d;
    end
  end

  assign core_rst  = (state_q == IDLE) || (state_q == RST_HOLD);
  assign busy      = (state_q == RST_HOLD) || (state_q == RUN);
  assign done      = pass_q | fail_q;
  assign passed    = pass_q;
  assign failed    = fail_q;
  assign timed_out = to_q;
  assign cycles    = cyc_q;

endmodule

// File: tb/tb_riscv_test_sequencer.sv
// Bench: random/directed runs on two sequencer instances (long and
// short timeout) checked against a per-run outcome model.
module tb_riscv_test_sequencer;

  localparam logic [31:0] PASS = 32'h44;
  localparam int          STALL = 16;
  localparam int          TO_A = 5000;
  localparam int          TO_B = 50;
  localparam int          RC_A = 1;
  localparam int          RC_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b;
  logic [31:0] pc, gp;

  logic        cr_a, bz_a, dn_a, ps_a, fl_a, to_a, st_a;
  logic        cr_b, bz_b, dn_b, ps_b, fl_b, to_b, st_b;
  logic [31:0] cy_a, cy_b;

  riscv_test_sequencer #(
    .RESET_CYCLES(RC_A),
    .TIMEOUT_TICKS(32'(TO_A))
  ) u_a (
    .clk(clk), .rst(rst), .start(start_a),
    .pc(pc), .gp(gp),
    .core_rst(cr_a), .busy(bz_a), .done(dn_a),
    .passed(ps_a), .failed(fl_a),
    .timed_out(to_a), .stalled(st_a),
    .cycles(cy_a)
  );

  riscv_test_sequencer #(
    .RESET_CYCLES(RC_B),
    .TIMEOUT_TICKS(32'(TO_B))
  ) u_b (
    .clk(clk), .rst(rst), .start(start_b),
    .pc(pc), .gp(gp),
    .core_rst(cr_b), .busy(bz_b), .done(dn_b),
    .passed(ps_b), .failed(fl_b),
    .timed_out(to_b), .stalled(st_b),
    .cycles(cy_b)
  );

  logic        sel;
  logic        o_cr, o_bz, o_dn, o_ps, o_fl, o_to, o_st;
  logic [31:0] o_cy;
  assign o_cr = sel ? cr_b : cr_a;
  assign o_bz = sel ? bz_b : bz_a;
  assign o_dn = sel ? dn_b : dn_a;
  assign o_ps = sel ? ps_b : ps_a;
  assign o_fl = sel ? fl_b : fl_a;
  assign o_to = sel ? to_b : to_a;
  assign o_st = sel ? st_b : st_a;
  assign o_cy = sel ? cy_b : cy_a;

  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel) start_b = v;
    else     start_a = v;
  endtask

  task automatic chk_idle(input string tag);
    chkb({tag, "_core_rst"}, o_cr, 1'b1);
    chkb({tag, "_busy"}, o_bz, 1'b0);
    chkb({tag, "_done"}, o_dn, 1'b0);
    chkb({tag, "_passed"}, o_ps, 1'b0);
    chkb({tag, "_failed"}, o_fl, 1'b0);
    chkb({tag, "_timed_out"}, o_to, 1'b0);
    chkb({tag, "_stalled"}, o_st, 1'b0);
    chk({tag, "_cycles"}, o_cy, 32'd0);
  endtask

  // One test run: pcs[k] is presented in RUN cycle k.
  task automatic run_case(input logic s, input int match_at,
                          input logic [31:0] gpv, input int rst_at,
                          input bit stuck);
    logic [31:0] pcs[$];
    int          to, rc, end_k, run, hold, n;
    bit          hit, stl;
    logic [31:0] v, cy_hold;
    logic        ps_hold;
    sel = s;
    to  = s ? TO_B : TO_A;
    rc  = s ? RC_B : RC_A;
    pcs.delete();
    for (int k = 0; k < to; k++) begin
      v = stuck ? 32'h80 : $urandom;
      if (v == PASS) v = v + 32'd1;
      pcs.push_back(v);
    end
    if (match_at >= 0) pcs[match_at] = PASS;

    end_k = to - 1;
    hit = 0;
    stl = 0;
    run = 0;
    for (int k = 0; k < to; k++) begin
      if (k > 0 && pcs[k] == pcs[k-1]) run++;
      else                             run = 0;
      if (pcs[k] == PASS) begin
        hit = 1; end_k = k; break;
      end
`ifdef TEST_SEQ_STALL_DETECT_EN
      if (run >= STALL) begin
        stl = 1; end_k = k; break;
      end
`endif
    end

    @(negedge clk);
    set_start(1'b1);
    @(negedge clk);
    set_start(1'b0);
    hold = 0;
    while (o_cr && hold < 300) begin
      chkb("hold_busy", o_bz, 1'b1);
      hold++;
      @(negedge clk);
    end
    chk("hold_len", 32'(hold), 32'(rc));
    chk("run_cycles0", o_cy, 32'd0);

    gp = gpv;
    n = 0;
    for (int k = 0; k < to + 5; k++) begin
      if (k == rst_at) begin
        rst = 1'b1;
        set_start(1'b1);
        @(negedge clk);
        rst = 1'b0;
        set_start(1'b0);
        chk_idle("midrst");
        return;
      end
      pc = (k < to) ? pcs[k] : 32'h0;
      set_start(k == 3);
      @(negedge clk);
      set_start(1'b0);
      n++;
      if (o_dn) break;
    end
    chk("end_len", 32'(n), 32'(end_k + 1));
    chk("end_cycles", o_cy, 32'(end_k + 1));
    chkb("end_passed", o_ps, hit && gpv == 32'h1);
    chkb("end_failed", o_fl, !(hit && gpv == 32'h1));
    chkb("end_timed_out", o_to, !hit && !stl);
    chkb("end_stalled", o_st, stl);
    chkb("end_done", o_dn, 1'b1);
    chkb("end_core_rst", o_cr, 1'b0);
    chkb("end_busy", o_bz, 1'b0);

    cy_hold = o_cy;
    ps_hold = o_ps;
    repeat (3) begin
      pc = $urandom;
      gp = $urandom_range(0, 1);
      @(negedge clk);
    end
    chk("done_hold_cycles", o_cy, cy_hold);
    chkb("done_hold_passed", o_ps, ps_hold);
    chkb("done_hold_one", o_ps & o_fl, 1'b0);
  endtask

  initial begin
    logic        s;
    int          m;
    logic [31:0] g;
    rst = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    pc = '0;
    gp = '0;
    sel = 1'b0;
    repeat (2) @(negedge clk);
    chk_idle("rst_a");
    sel = 1'b1;
    chk_idle("rst_b");
    rst = 1'b0;

    run_case(1'b0, 100, 32'h1, -1, 1'b0);
    run_case(1'b0, 100, 32'h5, -1, 1'b0);
    run_case(1'b1, -1, 32'h1, -1, 1'b0);
    run_case(1'b1, TO_B - 1, 32'h1, -1, 1'b0);
    run_case(1'b0, 60, 32'h1, 20, 1'b0);
    run_case(1'b0, 30, 32'h1, -1, 1'b0);
    run_case(1'b1, 0, 32'h0, -1, 1'b0);
    run_case(1'b1, -1, 32'h1, -1, 1'b1);

    for (int i = 0; i < 10; i++) begin
      s = 1'($urandom_range(0, 1));
      if (s) m = int'($urandom_range(0, TO_B + 10)) - 10;
      else   m = int'($urandom_range(0, 200));
      g = ($urandom_range(0, 1) == 1) ? 32'h1 : $urandom;
      run_case(s, m, g, -1, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
